// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_t;

  // Counter must hold W = N+1 iterations.
  function automatic int count_w(input int n);
    return $clog2(n + 2);
  endfunction

  function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_uc.sv
// Booth control unit: IDLE/RUN FSM, iteration counter and datapath strobes.
module booth_uc
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic q_menos1,
  output logic Carga_A,
  output logic Carga_QM,
  output logic Desplaza_AQ,
  output logic Reset_A,
  output logic Resta,
  output logic ultima,
  output logic Fin,
  output logic busy
);

  localparam int W  = N + 1;
  localparam int CW = count_w(N);

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg, count_next;
  logic           fin_reg, fin_next;
  booth_op_t      op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      fin_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      fin_reg   <= fin_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    fin_next    = 1'b0;
    Carga_A     = 1'b0;
    Carga_QM    = 1'b0;
    Desplaza_AQ = 1'b0;
    Reset_A     = 1'b0;
    Resta       = 1'b0;
    ultima      = 1'b0;
    op          = booth_decode(q0, q_menos1);
    case (state_reg)
      IDLE: begin
        if (start) begin
          Carga_QM   = 1'b1;
          Reset_A    = 1'b1;
          count_next = CW'(W);
          state_next = RUN;
        end
      end
      RUN: begin
        Desplaza_AQ = 1'b1;
        Carga_A     = (op != NOP);
        Resta       = (op == SUB);
        count_next  = count_reg - 1'b1;
        // Last iteration: product is captured on this edge, Fin follows.
        if (count_reg == CW'(1)) begin
          ultima     = 1'b1;
          fin_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Fin  = fin_reg;
  assign busy = (state_reg == RUN);

endmodule

// File: rtl/booth_mul_n.sv
// Parametrised sequential radix-2 Booth multiplier, signed or unsigned N x N -> 2N.
module booth_mul_n
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  output logic           busy,
  output logic [2*N-1:0] result,
  output logic           Fin
);

  localparam int W = N + 1;

  logic [W-1:0]   a_reg, q_reg, m_reg;
  logic           qm1_reg;
  logic [2*N-1:0] result_reg;

  logic [W-1:0]   a_sum, a_shift, q_shift;
  logic [2*N-1:0] result_next;

  logic carga_a, carga_qm, desplaza_aq, reset_a, resta, ultima;

  // One extra bit lets the same signed Booth core handle unsigned operands.
  function automatic logic [W-1:0] ext(input logic [N-1:0] v, input logic s);
    return {s & v[N-1], v};
  endfunction

  booth_uc #(.N(N)) u_uc (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .q0         (q_reg[0]),
    .q_menos1   (qm1_reg),
    .Carga_A    (carga_a),
    .Carga_QM   (carga_qm),
    .Desplaza_AQ(desplaza_aq),
    .Reset_A    (reset_a),
    .Resta      (resta),
    .ultima     (ultima),
    .Fin        (Fin),
    .busy       (busy)
  );

  always_comb begin
    a_sum = a_reg;
    if (carga_a) a_sum = resta ? (a_reg - m_reg) : (a_reg + m_reg);
  end

  assign a_shift = {a_sum[W-1], a_sum[W-1:1]};

  generate
    for (genvar gi = 0; gi < W - 1; gi++) begin : g_qshift
      assign q_shift[gi] = q_reg[gi+1];
    end
  endgenerate
  assign q_shift[W-1] = a_sum[0];

  // Low 2N bits of the shifted {A,Q}; the top two bits never carry product data.
  assign result_next = {a_shift[N-2:0], q_shift};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg      <= '0;
      q_reg      <= '0;
      m_reg      <= '0;
      qm1_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      if (reset_a) begin
        a_reg   <= '0;
        qm1_reg <= 1'b0;
      end
      if (carga_qm) begin
        m_reg <= ext(multiplicando, signed_mode);
        q_reg <= ext(multiplicador, signed_mode);
      end
      if (desplaza_aq) begin
        a_reg   <= a_shift;
        q_reg   <= q_shift;
        qm1_reg <= q_reg[0];
      end
      if (ultima) result_reg <= result_next;
    end
  end

  assign result = result_reg;

endmodule
